// File: rtl/uart_rx_model.sv
// UART 8N1 receiver with RX FIFO and a read-only register view.
// Exposes the RBR (0x00) and LSR (0x14) registers on a simple read bus.
module uart_rx_model #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        wr,
    input  logic [31:0] wdata,
    input  logic        rd,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        rx
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] HALF  = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] FULL  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BONE  = BW'(1);
    localparam logic [AW-1:0] PONE  = AW'(1);
    localparam logic [AW:0]   CONE  = (AW + 1)'(1);
    localparam logic [AW:0]   DEPTH = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [2:0]    bitcnt, bit_n;
    logic [BW-1:0] baud, baud_n;
    logic [7:0]    shreg, sh_n;
    logic          rx_s1, rxs;
    logic          push, fe_set, expire;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic          oe, fe;
    logic          pop, push_ok, oe_set, lsr_rd, dr;
    logic [31:0]   rdata_n;
    logic          unused_bus;

    assign unused_bus = ^{wr, wdata};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rxs   <= rx_s1;
        end
    end

    assign expire = (baud == '0);

    always_comb begin
        state_n = state;
        bit_n   = bitcnt;
        baud_n  = baud;
        sh_n    = shreg;
        push    = 1'b0;
        fe_set  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_n = START;
                    baud_n  = HALF;
                end
            end
            START: begin
                if (!expire) begin
                    baud_n = baud - BONE;
                end else if (rxs) begin
                    state_n = IDLE;
                end else begin
                    state_n = DATA;
                    bit_n   = 3'd0;
                    baud_n  = FULL;
                end
            end
            DATA: begin
                if (!expire) begin
                    baud_n = baud - BONE;
                end else begin
                    sh_n[bitcnt] = rxs;
                    baud_n       = FULL;
                    if (bitcnt == 3'd7) state_n = STOP;
                    else bit_n = bitcnt + 3'd1;
                end
            end
            STOP: begin
                if (!expire) begin
                    baud_n = baud - BONE;
                end else begin
                    state_n = IDLE;
                    push    = rxs;
                    fe_set  = ~rxs;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state  <= IDLE;
            bitcnt <= 3'd0;
            baud   <= '0;
            shreg  <= 8'h00;
        end else begin
            state  <= state_n;
            bitcnt <= bit_n;
            baud   <= baud_n;
            shreg  <= sh_n;
        end
    end

    // A pop in the same cycle frees a slot even when the FIFO is full.
    assign dr      = (count != '0);
    assign pop     = cs & rd & ~rvalid & (addr == 5'h00) & dr;
    assign lsr_rd  = cs & rd & ~rvalid & (addr == 5'h14);
    assign push_ok = push & ((count < DEPTH) | pop);
    assign oe_set  = push & ~push_ok;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= shreg;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            oe    <= 1'b0;
            fe    <= 1'b0;
        end else begin
            if (push_ok) wp <= wp + PONE;
            if (pop) rp <= rp + PONE;
            case ({push_ok, pop})
                2'b10:   count <= count + CONE;
                2'b01:   count <= count - CONE;
                default: count <= count;
            endcase
            oe <= oe_set | (oe & ~lsr_rd);
            fe <= fe_set | (fe & ~lsr_rd);
        end
    end

    always_comb begin
        rdata_n = 32'h0;
        case (addr)
            5'h00:   rdata_n = dr ? {24'h0, mem[rp]} : 32'h0;
            5'h14:   rdata_n = {25'h0, 1'b1, 1'b1, 1'b0, fe, 1'b0, oe, dr};
            default: rdata_n = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rdata  <= 32'h0;
            rvalid <= 1'b0;
        end else begin
            rdata  <= rdata_n;
            rvalid <= rd & ~rvalid;
        end
    end

endmodule

// File: tb/tb_uart_rx_model.sv
// Bench for uart_rx_model: serial stimulus, register reads and a
// scoreboard that matches every rvalid beat against queued expectations.
module tb_uart_rx_model;

    logic        clk;
    logic        nreset;
    logic        cs;
    logic [4:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic        rd;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rx;

    int total = 0;
    int bad   = 0;
    logic [31:0] expq [$];
    string       nameq [$];

    uart_rx_model #(.CLKS_PER_BIT(16), .FIFO_DEPTH(16)) dut (
        .clk(clk),
        .nreset(nreset),
        .cs(cs),
        .addr(addr),
        .wr(wr),
        .wdata(wdata),
        .rd(rd),
        .rdata(rdata),
        .rvalid(rvalid),
        .rx(rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (nreset && rvalid) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rvalid: got rdata=%h, no read pending", rdata);
            end else begin
                logic [31:0] e;
                string n;
                e = expq.pop_front();
                n = nameq.pop_front();
                if (rdata !== e) begin
                    bad++;
                    $display("FAIL %s: got %h expected %h", n, rdata, e);
                end
            end
        end
    end

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    task automatic rd_reg(input logic [4:0] a, input logic [31:0] e, input string n);
        expq.push_back(e);
        nameq.push_back(n);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(posedge clk);
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; addr = 5'h1f;
        check({n, "_rvalid_hi"}, {31'h0, rvalid}, 32'h1);
        @(negedge clk);
        check({n, "_rvalid_lo"}, {31'h0, rvalid}, 32'h0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
        rx = stop;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        nreset = 1'b0; cs = 1'b0; addr = 5'h1f; wr = 1'b0;
        wdata = 32'h0; rd = 1'b0; rx = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rdata", rdata, 32'h0);
        check("reset_rvalid", {31'h0, rvalid}, 32'h0);
        nreset = 1'b1;
        repeat (20) @(negedge clk);

        // writes are ignored
        cs = 1'b1; wr = 1'b1; addr = 5'h00; wdata = 32'hdeadbeef;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; wdata = 32'h0;
        rd_reg(5'h14, 32'h60, "lsr_idle");
        rd_reg(5'h00, 32'h0, "rbr_idle");

        send_byte(8'h41, 1'b1);
        rd_reg(5'h14, 32'h61, "lsr_dr");
        rd_reg(5'h00, 32'h41, "rbr_41");
        rd_reg(5'h14, 32'h60, "lsr_after_41");
        rd_reg(5'h10, 32'h0, "other_addr");

        for (int i = 1; i <= 17; i++) send_byte(8'(i), 1'b1);
        rd_reg(5'h14, 32'h63, "lsr_oe");
        for (int i = 1; i <= 16; i++) rd_reg(5'h00, 32'(i), "rbr_fifo");
        rd_reg(5'h14, 32'h60, "lsr_oe_cleared");
        rd_reg(5'h00, 32'h0, "rbr_drained");

        send_byte(8'h55, 1'b0);
        rd_reg(5'h14, 32'h68, "lsr_fe");
        rd_reg(5'h00, 32'h0, "rbr_fe_empty");
        rd_reg(5'h14, 32'h60, "lsr_fe_cleared");

        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        rd_reg(5'h14, 32'h60, "lsr_glitch");
        rd_reg(5'h00, 32'h0, "rbr_glitch");

        // reset in the middle of 0xA5's data bits, line idle at release
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        nreset = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_rdata", rdata, 32'h0);
        nreset = 1'b1;
        repeat (40) @(negedge clk);
        send_byte(8'h3c, 1'b1);
        rd_reg(5'h14, 32'h61, "lsr_after_reset");
        rd_reg(5'h00, 32'h3c, "rbr_3c");
        rd_reg(5'h14, 32'h60, "lsr_reset_empty");

        // held rd gives alternating rvalid beats
        expq.push_back(32'h60); nameq.push_back("lsr_held_a");
        expq.push_back(32'h60); nameq.push_back("lsr_held_b");
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = 5'h14;
        repeat (4) @(negedge clk);
        cs = 1'b0; rd = 1'b0; addr = 5'h1f;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 16; i++) send_byte(8'(8'h80 + i), 1'b1);
        // rx falls at the first negedge; the STOP push lands on posedge 155
        fork
            send_byte(8'h7e, 1'b1);
            begin
                @(negedge clk);
                repeat (154) @(posedge clk);
                rd_reg(5'h00, 32'h80, "rbr_pop_at_push");
            end
        join
        rd_reg(5'h14, 32'h61, "lsr_no_oe");
        for (int i = 1; i < 16; i++) rd_reg(5'h00, 32'(8'h80 + i), "rbr_full");
        rd_reg(5'h00, 32'h7e, "rbr_last_7e");
        rd_reg(5'h00, 32'h0, "rbr_final_empty");
        rd_reg(5'h14, 32'h60, "lsr_final");

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(expq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
